draw_box_multi: RTL and testbench

- Overlays up to BOX_NUM rectangular outlines on a streamed RGB image.
- Each box has its own coordinates, colour and enable. Line thickness is runtime-selectable.
- Sits in the video pipeline after the detection stage (frame-diff bounding box or similar) and before display output.
- Pixel position comes from valid/vsync activity, not fixed timing totals, so any resolution or blanking works.

---
 rtl/draw_box_multi.sv | 168 ++++++++++++++++
 tb/tb_draw_box_multi.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_box_multi.sv
// Overlays up to BOX_NUM rectangular outlines on a streamed RGB image.
// Box settings are latched per frame; pixel position is derived from valid/vsync activity.
module draw_box_multi #(
  parameter int DATA_W  = 24,
  parameter int BOX_NUM = 4,
  parameter int COORD_W = 11,
  parameter int THICK_W = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pre_img_vsync,
  input  logic                       pre_img_hsync,
  input  logic                       pre_img_valid,
  input  logic [DATA_W-1:0]          pre_img_data,
  input  logic [BOX_NUM-1:0]         box_en,
  input  logic [BOX_NUM*COORD_W-1:0] box_top,
  input  logic [BOX_NUM*COORD_W-1:0] box_bottom,
  input  logic [BOX_NUM*COORD_W-1:0] box_left,
  input  logic [BOX_NUM*COORD_W-1:0] box_right,
  input  logic [BOX_NUM*DATA_W-1:0]  box_color,
  input  logic [THICK_W-1:0]         line_thick,
  output logic                       post_img_vsync,
  output logic                       post_img_hsync,
  output logic                       post_img_valid,
  output logic [DATA_W-1:0]          post_img_data
);

  localparam int CW1 = COORD_W + 1;

  function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
    return (&v) ? v : v + COORD_W'(1);
  endfunction

  logic                       vsync_d, valid_d;
  logic [COORD_W-1:0]         x_cnt, y_cnt;
  logic [BOX_NUM-1:0]         sh_en;
  logic [BOX_NUM*COORD_W-1:0] sh_top, sh_bottom, sh_left, sh_right;
  logic [BOX_NUM*DATA_W-1:0]  sh_color;
  logic [THICK_W-1:0]         sh_thick;

  logic vs_rise, val_fall;
  assign vs_rise  = pre_img_vsync & ~vsync_d;
  assign val_fall = ~pre_img_valid & valid_d;

  // Position counters and per-frame shadow registers; a vsync rising edge overrides everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d   <= 1'b0;
      valid_d   <= 1'b0;
      x_cnt     <= '0;
      y_cnt     <= '0;
      sh_en     <= '0;
      sh_top    <= '0;
      sh_bottom <= '0;
      sh_left   <= '0;
      sh_right  <= '0;
      sh_color  <= '0;
      sh_thick  <= '0;
    end else begin
      vsync_d <= pre_img_vsync;
      valid_d <= pre_img_valid;
      if (vs_rise) begin
        x_cnt     <= '0;
        y_cnt     <= '0;
        sh_en     <= box_en;
        sh_top    <= box_top;
        sh_bottom <= box_bottom;
        sh_left   <= box_left;
        sh_right  <= box_right;
        sh_color  <= box_color;
        sh_thick  <= line_thick;
      end else if (pre_img_valid) begin
        x_cnt <= sat_inc(x_cnt);
      end else if (val_fall) begin
        x_cnt <= '0;
        y_cnt <= sat_inc(y_cnt);
      end
    end
  end

  logic [CW1-1:0]     t_eff;
  logic [CW1-1:0]     x_ext, y_ext;
  logic [BOX_NUM-1:0] hit_c;

  assign t_eff = (sh_thick == '0) ? CW1'(1) : CW1'(sh_thick);
  assign x_ext = CW1'(x_cnt);
  assign y_ext = CW1'(y_cnt);

  // Inner bounds may wrap when right/bottom < t, but then x/y can never be both outer and inner
  for (genvar i = 0; i < BOX_NUM; i++) begin : g_box
    logic [COORD_W-1:0] l, r, tp, bt;
    logic [CW1-1:0]     il, ir, it, ib;
    logic               legal, outer, inner;
    assign l      = sh_left[i*COORD_W +: COORD_W];
    assign r      = sh_right[i*COORD_W +: COORD_W];
    assign tp     = sh_top[i*COORD_W +: COORD_W];
    assign bt     = sh_bottom[i*COORD_W +: COORD_W];
    assign il     = CW1'(l) + t_eff;
    assign ir     = CW1'(r) - t_eff;
    assign it     = CW1'(tp) + t_eff;
    assign ib     = CW1'(bt) - t_eff;
    assign legal  = (l <= r) && (tp <= bt);
    assign outer  = (x_cnt >= l) && (x_cnt <= r) && (y_cnt >= tp) && (y_cnt <= bt);
    assign inner  = (ir >= il) && (ib >= it) && (x_ext >= il) && (x_ext <= ir) &&
                    (y_ext >= it) && (y_ext <= ib);
    assign hit_c[i] = sh_en[i] & legal & outer & ~inner;
  end

  logic [DATA_W-1:0] col_c;
  logic              any_c;

  always_comb begin
    col_c = '0;
    any_c = 1'b0;
    for (int i = BOX_NUM - 1; i >= 0; i--) begin
      if (hit_c[i]) begin
        col_c = sh_color[i*DATA_W +: DATA_W];
        any_c = 1'b1;
      end
    end
  end

  logic              vld_p1, vsync_p1, hsync_p1, hit_p1;
  logic [DATA_W-1:0] data_p1, color_p1;

  // Stage 1: hit detection registered alongside pixel and syncs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      vsync_p1 <= 1'b0;
      hsync_p1 <= 1'b0;
      hit_p1   <= 1'b0;
      data_p1  <= '0;
      color_p1 <= '0;
    end else begin
      vld_p1   <= pre_img_valid;
      vsync_p1 <= pre_img_vsync;
      hsync_p1 <= pre_img_hsync;
      hit_p1   <= any_c;
      data_p1  <= pre_img_data;
      color_p1 <= col_c;
    end
  end

  logic              vld_p2, vsync_p2, hsync_p2;
  logic [DATA_W-1:0] data_p2;

  // Stage 2: overlay applied to valid pixels only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2   <= 1'b0;
      vsync_p2 <= 1'b0;
      hsync_p2 <= 1'b0;
      data_p2  <= '0;
    end else begin
      vld_p2   <= vld_p1;
      vsync_p2 <= vsync_p1;
      hsync_p2 <= hsync_p1;
      data_p2  <= (vld_p1 && hit_p1) ? color_p1 : data_p1;
    end
  end

  assign post_img_vsync = vsync_p2;
  assign post_img_hsync = hsync_p2;
  assign post_img_valid = vld_p2;
  assign post_img_data  = data_p2;

endmodule

// File: tb/tb_draw_box_multi.sv
// Randomised scoreboard bench for draw_box_multi with a per-frame geometric reference model.
module tb_draw_box_multi;
  localparam int DATA_W  = 24;
  localparam int BOX_NUM = 4;
  localparam int COORD_W = 11;
  localparam int THICK_W = 3;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       pre_img_vsync, pre_img_hsync, pre_img_valid;
  logic [DATA_W-1:0]          pre_img_data;
  logic [BOX_NUM-1:0]         box_en;
  logic [BOX_NUM*COORD_W-1:0] box_top, box_bottom, box_left, box_right;
  logic [BOX_NUM*DATA_W-1:0]  box_color;
  logic [THICK_W-1:0]         line_thick;
  logic                       post_img_vsync, post_img_hsync, post_img_valid;
  logic [DATA_W-1:0]          post_img_data;

  draw_box_multi #(.DATA_W(DATA_W), .BOX_NUM(BOX_NUM), .COORD_W(COORD_W), .THICK_W(THICK_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .pre_img_vsync(pre_img_vsync), .pre_img_hsync(pre_img_hsync),
    .pre_img_valid(pre_img_valid), .pre_img_data(pre_img_data),
    .box_en(box_en), .box_top(box_top), .box_bottom(box_bottom),
    .box_left(box_left), .box_right(box_right), .box_color(box_color),
    .line_thick(line_thick),
    .post_img_vsync(post_img_vsync), .post_img_hsync(post_img_hsync),
    .post_img_valid(post_img_valid), .post_img_data(post_img_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                cyc;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sync_ok_from = 3;
  logic [2:0] hist [0:65535];

  // requested configuration (drives inputs) and the frame-latched copy the model uses
  int                c_en[BOX_NUM], c_t[BOX_NUM], c_b[BOX_NUM], c_l[BOX_NUM], c_r[BOX_NUM];
  logic [DATA_W-1:0] c_col[BOX_NUM];
  int                c_thick;
  int                s_en[BOX_NUM], s_t[BOX_NUM], s_b[BOX_NUM], s_l[BOX_NUM], s_r[BOX_NUM];
  logic [DATA_W-1:0] s_col[BOX_NUM];
  int                s_thick;

  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [DATA_W-1:0] model(int x, int y, logic [DATA_W-1:0] d);
    int t;
    t = (s_thick == 0) ? 1 : s_thick;
    for (int i = 0; i < BOX_NUM; i++) begin
      if (s_en[i] != 0 && s_l[i] <= s_r[i] && s_t[i] <= s_b[i] &&
          x >= s_l[i] && x <= s_r[i] && y >= s_t[i] && y <= s_b[i] &&
          !(x >= s_l[i] + t && x <= s_r[i] - t && y >= s_t[i] + t && y <= s_b[i] - t))
        return s_col[i];
    end
    return d;
  endfunction

  task automatic clear_cfg();
    for (int i = 0; i < BOX_NUM; i++) begin
      c_en[i] = 0; c_t[i] = 0; c_b[i] = 0; c_l[i] = 0; c_r[i] = 0; c_col[i] = '0;
    end
    c_thick = 1;
  endtask

  task automatic set_box(int i, int tp, int bt, int l, int r, logic [DATA_W-1:0] col);
    c_en[i] = 1; c_t[i] = tp; c_b[i] = bt; c_l[i] = l; c_r[i] = r; c_col[i] = col;
  endtask

  task automatic apply_cfg();
    for (int i = 0; i < BOX_NUM; i++) begin
      box_en[i] = (c_en[i] != 0);
      box_top[i*COORD_W +: COORD_W]    = COORD_W'(c_t[i]);
      box_bottom[i*COORD_W +: COORD_W] = COORD_W'(c_b[i]);
      box_left[i*COORD_W +: COORD_W]   = COORD_W'(c_l[i]);
      box_right[i*COORD_W +: COORD_W]  = COORD_W'(c_r[i]);
      box_color[i*DATA_W +: DATA_W]    = c_col[i];
    end
    line_thick = THICK_W'(c_thick);
  endtask

  task automatic drive(bit v, bit vs, logic [DATA_W-1:0] d);
    @(posedge clk);
    #1;
    pre_img_valid = v;
    pre_img_vsync = vs;
    pre_img_hsync = 1'($urandom);
    pre_img_data  = d;
  endtask

  task automatic start_frame();
    apply_cfg();
    drive(0, 1, DATA_W'($urandom));
    for (int i = 0; i < BOX_NUM; i++) begin
      s_en[i] = c_en[i]; s_t[i] = c_t[i]; s_b[i] = c_b[i];
      s_l[i] = c_l[i]; s_r[i] = c_r[i]; s_col[i] = c_col[i];
    end
    s_thick = c_thick;
    drive(0, 1, DATA_W'($urandom));
    drive(0, 0, DATA_W'($urandom));
    drive(0, 0, DATA_W'($urandom));
  endtask

  task automatic send_pixels(int y, int x0, int n);
    logic [DATA_W-1:0] d;
    for (int x = x0; x < x0 + n; x++) begin
      d = DATA_W'($urandom);
      drive(1, 0, d);
      q.push_back('{model(x, y, d), cyc});
    end
  endtask

  task automatic send_gap();
    int n;
    n = $urandom_range(1, 3);
    for (int k = 0; k < n; k++) drive(0, 0, DATA_W'($urandom));
  endtask

  task automatic send_line(int y, int w);
    send_pixels(y, 0, w);
    send_gap();
  endtask

  task automatic send_frame(int w, int h);
    start_frame();
    for (int y = 0; y < h; y++) send_line(y, w);
  endtask

  task automatic check_zero(string name);
    checks++;
    if ({post_img_vsync, post_img_hsync, post_img_valid, post_img_data} != '0) begin
      errors++;
      $display("FAIL %s got vs=%0b hs=%0b v=%0b d=%06h required all zero", name,
               post_img_vsync, post_img_hsync, post_img_valid, post_img_data);
    end
  endtask

  // monitor: syncs and idle data against input history, valid pixels against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    logic [2:0] h;
    hist[cyc % 65536] = {pre_img_valid, pre_img_vsync, pre_img_hsync};
    if (rst_n) begin
      if (cyc >= sync_ok_from) begin
        h = hist[(cyc - 2) % 65536];
        checks++;
        if ({post_img_valid, post_img_vsync, post_img_hsync} !== h) begin
          errors++;
          $display("FAIL sync_align cyc=%0d got v/vs/hs=%03b required %03b", cyc,
                   {post_img_valid, post_img_vsync, post_img_hsync}, h);
        end
      end
      if (post_img_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pixel cyc=%0d got %06h required no output", cyc, post_img_data);
        end else begin
          e = q.pop_front();
          if (post_img_data !== e.data || cyc != e.cyc + 2) begin
            errors++;
            $display("FAIL pixel cyc=%0d got %06h required %06h at cyc %0d", cyc,
                     post_img_data, e.data, e.cyc + 2);
          end
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog timeout got no finish required completion");
    $fatal(1);
  end

  initial begin
    int w, h;
    rst_n = 1'b0;
    pre_img_vsync = 0; pre_img_hsync = 0; pre_img_valid = 0; pre_img_data = '0;
    clear_cfg();
    apply_cfg();
    for (int i = 0; i < BOX_NUM; i++) begin
      s_en[i] = 0; s_t[i] = 0; s_b[i] = 0; s_l[i] = 0; s_r[i] = 0; s_col[i] = '0;
    end
    s_thick = 0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_state");
    rst_n = 1'b1;
    sync_ok_from = cyc + 3;

    // before any vsync the block must be passthrough even with a box requested
    set_box(0, 0, 3, 0, 5, 24'hABCDEF);
    apply_cfg();
    send_line(0, 8);

    clear_cfg(); set_box(0, 2, 5, 3, 10, 24'hFF0000); c_thick = 1;
    send_frame(16, 8);
    c_thick = 2;
    send_frame(16, 8);
    c_l[0] = 3; c_r[0] = 5;
    send_frame(16, 8);
    clear_cfg(); set_box(0, 0, 3, 0, 3, 24'hFF0000); set_box(1, 2, 6, 2, 6, 24'h00FF00);
    send_frame(16, 8);

    // mid-frame edit only takes effect on the next frame
    clear_cfg(); set_box(0, 2, 5, 3, 10, 24'hFF0000);
    start_frame();
    for (int y = 0; y < 4; y++) send_line(y, 16);
    c_l[0] = 8;
    apply_cfg();
    for (int y = 4; y < 8; y++) send_line(y, 16);
    send_frame(16, 8);
    c_l[0] = 9; c_r[0] = 4;
    send_frame(16, 8);

    // reset while pixels are in flight
    clear_cfg(); set_box(0, 2, 5, 3, 10, 24'hFF0000);
    start_frame();
    for (int y = 0; y < 3; y++) send_line(y, 16);
    send_pixels(3, 0, 5);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    pre_img_valid = 0; pre_img_vsync = 0; pre_img_hsync = 0;
    #1;
    check_zero("reset_midframe");
    q.delete();
    for (int i = 0; i < BOX_NUM; i++) s_en[i] = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      check_zero("reset_hold");
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sync_ok_from = cyc + 3;
    for (int y = 0; y < 3; y++) send_line(y, 16);
    send_frame(16, 8);

    for (int f = 0; f < 15; f++) begin
      clear_cfg();
      for (int i = 0; i < BOX_NUM; i++) begin
        c_en[i]  = $urandom_range(0, 3) != 0 ? 1 : 0;
        c_t[i]   = $urandom_range(0, 14);
        c_b[i]   = $urandom_range(0, 14);
        c_l[i]   = $urandom_range(0, 30);
        c_r[i]   = $urandom_range(0, 30);
        c_col[i] = DATA_W'($urandom);
      end
      c_thick = $urandom_range(0, 7);
      w = $urandom_range(8, 24);
      h = $urandom_range(4, 12);
      send_frame(w, h);
    end

    repeat (5) drive(0, 0, DATA_W'($urandom));
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
